// File: rtl/div_bank_ctrl.sv
// div_bank_ctrl: NB_DIV programmable clock dividers with a valid/ready config port.
// Optional macro DIVBANK_SHADOW_EN: updates to running channels wait for the wrap or SyncIn.
// Ports: ClkIn, Reset (sync, active-high), Cfg* request fields, CfgValid/CfgReady,
// SyncIn strobe, CfgErr pulse, Pending (shadow waiting), ClockOut (registered).
module div_bank_ctrl #(
  parameter int NB_DIV     = 24,
  parameter int CH_W       = 5,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 48,
  parameter int DEF_HIGH   = 24,
  parameter int DEF_PHASE  = 0
) (
  input  logic              ClkIn,
  input  logic              Reset,
  input  logic              CfgValid,
  output logic              CfgReady,
  input  logic [CH_W-1:0]   CfgChan,
  input  logic [CNT_W-1:0]  CfgPeriod,
  input  logic [CNT_W-1:0]  CfgHigh,
  input  logic [CNT_W-1:0]  CfgPhase,
  input  logic              CfgEnable,
  input  logic              SyncIn,
  output logic              CfgErr,
  output logic [NB_DIV-1:0] Pending,
  output logic [NB_DIV-1:0] ClockOut
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT
  } state_t;

  state_t state;

  logic [CH_W-1:0]  rChan;
  logic [CNT_W-1:0] rPeriod;
  logic [CNT_W-1:0] rHigh;
  logic [CNT_W-1:0] rPhase;
  logic             rEn;
  logic             reqOk;
  logic             commit;

  logic [CNT_W-1:0] period  [NB_DIV];
  logic [CNT_W-1:0] high    [NB_DIV];
  logic [CNT_W-1:0] phase   [NB_DIV];
  logic [CNT_W-1:0] cnt     [NB_DIV];
  logic [CNT_W-1:0] nextCnt [NB_DIV];
  logic [NB_DIV-1:0] en;
  logic [NB_DIV-1:0] hit;
  logic [NB_DIV-1:0] wrap;

  assign reqOk = (int'(rChan) < NB_DIV)
              && (rPeriod >= CNT_W'(2))
              && (rHigh != '0)
              && (rHigh < rPeriod)
              && (rPhase < rPeriod);

  assign commit = (state == COMMIT) && reqOk;

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      state    <= IDLE;
      CfgReady <= 1'b0;
      CfgErr   <= 1'b0;
    end else begin
      CfgErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CfgValid && CfgReady) begin
            rChan    <= CfgChan;
            rPeriod  <= CfgPeriod;
            rHigh    <= CfgHigh;
            rPhase   <= CfgPhase;
            rEn      <= CfgEnable;
            state    <= CHECK;
            CfgReady <= 1'b0;
          end else begin
            CfgReady <= 1'b1;
          end
        end
        CHECK: state <= COMMIT;
        COMMIT: begin
          CfgErr   <= !reqOk;
          state    <= IDLE;
          CfgReady <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The counter restarts at Phase when disabled or on sync; otherwise it wraps
  // at Period-1 so a shrinking period can never leave it out of range.
  always_comb begin
    for (int i = 0; i < NB_DIV; i++) begin
      hit[i]  = commit && (int'(rChan) == i);
      wrap[i] = cnt[i] >= (period[i] - CNT_W'(1));
      if (!en[i] || SyncIn) nextCnt[i] = phase[i];
      else if (wrap[i])     nextCnt[i] = '0;
      else                  nextCnt[i] = cnt[i] + CNT_W'(1);
    end
  end

`ifdef DIVBANK_SHADOW_EN
  logic [CNT_W-1:0]  sPeriod [NB_DIV];
  logic [CNT_W-1:0]  sHigh   [NB_DIV];
  logic [CNT_W-1:0]  sPhase  [NB_DIV];
  logic [NB_DIV-1:0] sEn;
  logic [NB_DIV-1:0] pend;

  assign Pending = pend;
`else
  assign Pending = '0;
`endif

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      for (int i = 0; i < NB_DIV; i++) begin
        period[i]   <= CNT_W'(DEF_PERIOD);
        high[i]     <= CNT_W'(DEF_HIGH);
        phase[i]    <= CNT_W'(DEF_PHASE);
        cnt[i]      <= CNT_W'(DEF_PHASE);
        en[i]       <= 1'b1;
        ClockOut[i] <= 1'b0;
`ifdef DIVBANK_SHADOW_EN
        sPeriod[i]  <= '0;
        sHigh[i]    <= '0;
        sPhase[i]   <= '0;
        sEn[i]      <= 1'b0;
        pend[i]     <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < NB_DIV; i++) begin
        ClockOut[i] <= en[i] && (cnt[i] < high[i]);
`ifdef DIVBANK_SHADOW_EN
        // A sync in the commit cycle would apply the shadow anyway, so the
        // new values go straight in; a fresh commit supersedes any old shadow.
        if (hit[i] && (!en[i] || SyncIn)) begin
          period[i] <= rPeriod;
          high[i]   <= rHigh;
          phase[i]  <= rPhase;
          en[i]     <= rEn;
          cnt[i]    <= rPhase;
          pend[i]   <= 1'b0;
        end else if (hit[i]) begin
          sPeriod[i] <= rPeriod;
          sHigh[i]   <= rHigh;
          sPhase[i]  <= rPhase;
          sEn[i]     <= rEn;
          pend[i]    <= 1'b1;
          cnt[i]     <= nextCnt[i];
        end else if (pend[i] && (SyncIn || wrap[i])) begin
          period[i] <= sPeriod[i];
          high[i]   <= sHigh[i];
          phase[i]  <= sPhase[i];
          en[i]     <= sEn[i];
          cnt[i]    <= sPhase[i];
          pend[i]   <= 1'b0;
        end else begin
          cnt[i] <= nextCnt[i];
        end
`else
        if (hit[i]) begin
          period[i] <= rPeriod;
          high[i]   <= rHigh;
          phase[i]  <= rPhase;
          en[i]     <= rEn;
          cnt[i]    <= rPhase;
        end else begin
          cnt[i] <= nextCnt[i];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_bank_ctrl.sv
// tb_div_bank_ctrl: randomized bench for div_bank_ctrl against a cycle model.
// Directed scenarios pin the model with literal expectations first.
module tb_div_bank_ctrl;
  localparam int NB = 24;
  localparam int CW = 5;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfgValid = 1'b0;
  logic [CW-1:0] chan = '0;
  logic [W-1:0]  per = '0;
  logic [W-1:0]  hi = '0;
  logic [W-1:0]  ph = '0;
  logic          enIn = 1'b1;
  logic          sync = 1'b0;
  logic          cfgReady;
  logic          cfgErr;
  logic [NB-1:0] pending;
  logic [NB-1:0] clockOut;

  always #5 clk = ~clk;

  div_bank_ctrl dut (
    .ClkIn     (clk),
    .Reset     (rst),
    .CfgValid  (cfgValid),
    .CfgReady  (cfgReady),
    .CfgChan   (chan),
    .CfgPeriod (per),
    .CfgHigh   (hi),
    .CfgPhase  (ph),
    .CfgEnable (enIn),
    .SyncIn    (sync),
    .CfgErr    (cfgErr),
    .Pending   (pending),
    .ClockOut  (clockOut)
  );

  // Behavioural model: per-channel settings and counters as plain integers.
  int mPer [NB];
  int mHi  [NB];
  int mPh  [NB];
  int mCnt [NB];
  bit mEn  [NB];
  int sPer [NB];
  int sHi  [NB];
  int sPh  [NB];
  bit sEn  [NB];
  bit [NB-1:0] mClk;
  bit [NB-1:0] mPend;
  bit mReady;
  bit mErr;
  bit reqAct;
  int commitAt;
  int cyc;
  int qChan, qPer, qHi, qPh;
  bit qEn;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      if (nBad <= 50)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic loadCh(int i, int p, int h, int f, bit e);
    mPer[i] = p;
    mHi[i]  = h;
    mPh[i]  = f;
    mEn[i]  = e;
    mCnt[i] = f;
  endtask

  task automatic advance(int i, bit s);
    if (!mEn[i] || s) mCnt[i] = mPh[i];
    else              mCnt[i] = (mCnt[i] + 1) % mPer[i];
  endtask

  task automatic modelStep();
    bit doCommit;
    bit s;
    bit hit;
    s = sync;
    if (rst) begin
      for (int i = 0; i < NB; i++) loadCh(i, 48, 24, 0, 1'b1);
      mClk = '0;
      mPend = '0;
      reqAct = 0;
      mReady = 0;
      mErr = 0;
      return;
    end
    doCommit = 0;
    mErr = 0;
    if (reqAct && cyc == commitAt) begin
      reqAct = 0;
      if (qChan < NB && qPer >= 2 && qHi >= 1 && qHi <= qPer - 1 && qPh < qPer)
        doCommit = 1;
      else
        mErr = 1;
    end else if (cfgValid && mReady) begin
      reqAct = 1;
      commitAt = cyc + 2;
      qChan = int'(chan);
      qPer = int'(per);
      qHi = int'(hi);
      qPh = int'(ph);
      qEn = enIn;
    end
    for (int i = 0; i < NB; i++) begin
      hit = doCommit && qChan == i;
      mClk[i] = mEn[i] && (mCnt[i] < mHi[i]);
`ifdef DIVBANK_SHADOW_EN
      if (hit && (!mEn[i] || s)) begin
        loadCh(i, qPer, qHi, qPh, qEn);
        mPend[i] = 0;
      end else if (hit) begin
        sPer[i] = qPer;
        sHi[i] = qHi;
        sPh[i] = qPh;
        sEn[i] = qEn;
        mPend[i] = 1;
        advance(i, 1'b0);
      end else if (mPend[i] && (s || mCnt[i] + 1 == mPer[i])) begin
        loadCh(i, sPer[i], sHi[i], sPh[i], sEn[i]);
        mPend[i] = 0;
      end else begin
        advance(i, s);
      end
`else
      if (hit) loadCh(i, qPer, qHi, qPh, qEn);
      else     advance(i, s);
`endif
    end
    mReady = !reqAct;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
    cyc++;
    chk("ClockOut", 32'(clockOut), 32'(mClk));
    chk("CfgReady", 32'(cfgReady), 32'(mReady));
    chk("CfgErr", 32'(cfgErr), 32'(mErr));
    chk("Pending", 32'(pending), 32'(mPend));
  endtask

  // Issues one request and stops at A+2, where commit/error is visible.
  task automatic cfgReq(int c, int p, int h, int f, bit e, bit expErr);
    for (int k = 0; k < 10 && !cfgReady; k++) tick();
    chk("ready_wait", 32'(cfgReady), 32'd1);
    chan = CW'(c);
    per = W'(p);
    hi = W'(h);
    ph = W'(f);
    enIn = e;
    cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
    chk("busy_A", 32'(cfgReady), 32'd0);
    tick();
    chk("busy_A1", 32'(cfgReady), 32'd0);
    tick();
    chk("ready_A2", 32'(cfgReady), 32'd1);
    chk("err_A2", 32'(cfgErr), 32'(expErr));
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_clk", 32'(clockOut), 32'd0);
    chk("rst_ready", 32'(cfgReady), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_ready", 32'(cfgReady), 32'd1);
    chk("rel_high", 32'(clockOut), 32'hFF_FFFF);
    repeat (23) tick();
    chk("high_24", 32'(clockOut), 32'hFF_FFFF);
    tick();
    chk("low_25", 32'(clockOut), 32'd0);
    repeat (23) tick();
    chk("low_48", 32'(clockOut), 32'd0);
    tick();
    chk("high_49", 32'(clockOut), 32'hFF_FFFF);

    cfgReq(3, 10, 3, 0, 1'b1, 1'b0);
`ifndef DIVBANK_SHADOW_EN
    tick();
    chk("ch3_A3", 32'(clockOut[3]), 32'd1);
    tick();
    tick();
    chk("ch3_A5", 32'(clockOut[3]), 32'd1);
    tick();
    chk("ch3_A6", 32'(clockOut[3]), 32'd0);
    repeat (7) tick();
    chk("ch3_A13", 32'(clockOut[3]), 32'd1);
`else
    chk("ch3_pend", 32'(pending[3]), 32'd1);
    repeat (60) tick();
`endif

    cfgReq(30, 10, 3, 0, 1'b1, 1'b1);
    tick();
    chk("err_once", 32'(cfgErr), 32'd0);
    cfgReq(2, 8, 8, 0, 1'b1, 1'b1);
    chk("rej_pend", 32'(pending), 32'(mPend));
    tick();

    cfgReq(0, 48, 24, 0, 1'b1, 1'b0);
    cfgReq(1, 48, 24, 24, 1'b1, 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int k = 0; k < 48; k++) begin
      tick();
      chk("sync_compl", 32'(clockOut[0] ^ clockOut[1]), 32'd1);
    end

    chan = CW'(4);
    per = W'(10);
    hi = W'(3);
    ph = W'(0);
    enIn = 1'b1;
    cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("abort_clk", 32'(clockOut), 32'hFF_FFFF);
    chk("abort_err", 32'(cfgErr), 32'd0);
    tick();
    chk("abort_err2", 32'(cfgErr), 32'd0);
    repeat (30) tick();
    chk("abort_ch4", 32'(clockOut[4]), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 799) == 0);
      cfgValid = ($urandom_range(0, 2) == 0);
      chan = CW'($urandom_range(0, 31));
      per = W'($urandom_range(0, 24));
      hi = W'($urandom_range(0, int'(per)));
      ph = W'($urandom_range(0, int'(per)));
      enIn = ($urandom_range(0, 4) != 0);
      sync = ($urandom_range(0, 24) == 0);
      tick();
    end
    rst = 1'b0;
    cfgValid = 1'b0;
    sync = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/div_bank_ctrl.md
# div_bank_ctrl

Programmable controller for a bank of `NB_DIV` clock-divider channels. Each channel has its own period, high time, phase and enable, held in per-channel registers. Software-side logic loads these over a valid/ready configuration port, and a sync strobe realigns all channels. The block replaces the fixed 48/24/0 divider bank wherever divide ratios must change at run time without runt pulses.

## Interface
- `NB_DIV`, 24, number of divider channels.
- `CH_W`, 5, channel index width; must satisfy 2^`CH_W` ≥ `NB_DIV`.
- `CNT_W`, 16, width of the per-channel counter and config fields.
- `DEF_PERIOD`, 48, per-channel period loaded at reset.
- `DEF_HIGH`, 24, per-channel high time loaded at reset.
- `DEF_PHASE`, 0, per-channel phase loaded at reset.
- `ClkIn` in 1, the single clock; all state changes on its rising edge.
- `Reset` in 1, synchronous, active-high.
- `CfgValid` in 1, configuration request valid.
- `CfgReady` out 1, controller can accept a request.
- `CfgChan` in `CH_W`, target channel index.
- `CfgPeriod` in `CNT_W`, new period in `ClkIn` cycles.
- `CfgHigh` in `CNT_W`, new high time in cycles.
- `CfgPhase` in `CNT_W`, counter load value applied on enable or sync.
- `CfgEnable` in 1, channel enable.
- `SyncIn` in 1, one-cycle strobe that realigns all enabled channels.
- `CfgErr` out 1, one-cycle pulse when a request is rejected.
- `Pending` out `NB_DIV`, per-channel flag: a shadow update is waiting.
- `ClockOut` out `NB_DIV`, divided clocks, registered.

## Operation
- **Channel datapath**
  - Counter `cnt` counts 0..`Period`−1, then wraps to 0.
  - `ClockOut[i]` is registered as `En & (cnt < High)`, evaluated on the counter value before the edge.
  - A disabled channel holds `cnt` = `Phase` and drives `ClockOut` = 0.
- **Configuration FSM** (IDLE → CHECK → COMMIT → IDLE)
  - IDLE: `CfgReady` = 1. A request is accepted when `CfgValid & CfgReady`; all `Cfg*` fields are latched.
  - CHECK: `CfgReady` = 0. The latched request is valid only if all of these hold:
    - `CfgChan` < `NB_DIV`
    - `Period` ≥ 2
    - 1 ≤ `High` ≤ `Period`−1
    - `Phase` < `Period`
  - COMMIT: `CfgReady` = 0.
    - Invalid request: `CfgErr` = 1 for exactly this cycle; no channel state changes.
    - Valid request: the update is applied (immediately, or via the shadow path described under Configuration).
  - Throughput is at most one request per 3 cycles.
- **Applying an update to a channel**
  - Config registers take the new values and `cnt` loads `Phase`.
  - This happens in the COMMIT cycle or at the later shadow apply point.
- **`SyncIn`**
  - Every enabled channel loads `cnt` ← `Phase` in the same cycle.
  - Any pending shadow update is applied in that same cycle.
  - If `SyncIn` coincides with a COMMIT, the committed values are the ones used by the sync for the addressed channel.
- **Arithmetic**
  - All comparisons are unsigned.
  - The counter never exceeds `Period`−1, including immediately after a period change.

## Timing
- **Reset values**
  - `ClockOut` = 0, `CfgErr` = 0, `Pending` = 0, `CfgReady` = 0.
  - FSM in IDLE.
  - Every channel set to `DEF_PERIOD`/`DEF_HIGH`/`DEF_PHASE` with enable = 1 and `cnt` = `DEF_PHASE`.
- **After reset release**
  - `CfgReady` = 1 from the first edge with `Reset` low.
  - With defaults, `ClockOut[i]` = 1 from that first edge for 24 cycles, then 0 for 24 cycles, repeating.
- **Configuration latency**
  - Accept at edge A, CHECK at A+1, new config and `CfgErr` at A+2.
  - In immediate mode, `ClockOut` reflects the new config from A+3.
- **Reset mid-transaction**
  - Any in-flight request is aborted and never committed.
  - All shadows are cleared.
- **Simultaneous accept and `SyncIn`**
  - Both take effect.
  - The sync does not stall the FSM.

## Configuration
- Macro: `DIVBANK_SHADOW_EN`.
- **Defined (glitch-free mode)**
  - A COMMIT to an enabled channel writes a shadow copy and sets `Pending[i]`.
  - The shadow is applied on the cycle where `cnt` = `Period`−1 (the wrap) or on `SyncIn`, whichever comes first; `Pending[i]` clears on that same edge.
  - A COMMIT to a disabled channel applies immediately.
  - A second COMMIT to a channel with `Pending[i]` set overwrites its shadow.
  - A disable request completes the current period before `ClockOut` goes to 0.
- **Undefined**
  - Every valid COMMIT applies immediately.
  - `Pending` is tied to 0.
  - Shadow registers are not synthesised.

## Test plan
- **Reset defaults:** Reset for 3 cycles, then release → every `ClockOut` bit shows 24 high / 24 low, all bits in phase; `CfgReady` = 1 on the first released edge.
- **Immediate reconfigure** (macro undefined): write chan 3 with `Period`=10, `High`=3, `Phase`=0 → `CfgReady` low for 2 cycles; `ClockOut[3]` is 3 high / 7 low from A+3; other channels undisturbed.
- **Rejected requests:** write chan 30, and separately `High`=`Period`=8 → `CfgErr` pulses at A+2; channel state unchanged; `Pending` unchanged.
- **Shadow update** (macro defined): mid-period write chan 5 with `Period`=20, `High`=10 → `Pending[5]` = 1; the old 48-cycle period completes; the new waveform starts at the wrap; `Pending[5]` clears on that edge.
- **Sync alignment:** set chan 0 `Phase`=0 and chan 1 `Phase`=24 (both `Period`=48, `High`=24), then pulse `SyncIn` → the two outputs are exactly complementary from the next edge.
- **Reset mid-transaction:** assert `Reset` in the CHECK cycle → no commit, no `CfgErr`, and chan config equals the defaults.
